// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the FSM state encoding, the NOP bubble word, the PC step,
// and a helper that word-aligns PC values.
package if_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ST_W = 2;

  typedef logic [ST_W-1:0] state_t;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_REQ  = 2'd1;
  localparam logic [ST_W-1:0] ST_WAIT = 2'd2;
  localparam logic [ST_W-1:0] ST_HOLD = 2'd3;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  // Clear the byte-offset bits so fetch addresses stay word-aligned.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer for a fetched instruction and its request PC.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_load            capture i_inst/i_pc
//   i_drain, i_flush  empty the buffer (drain = consumed, flush = discarded)
//   o_valid, o_inst, o_pc  buffer contents
module if_skid_buf
  import if_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_pc;

  // Emptying wins over loading; the two never coincide in the fetch FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
      r_pc    <= '0;
    end else if (i_flush || i_drain) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request
// outstanding, and feeds inst/PCplus4 to the IF/ID register, inserting
// NOP bubbles when nothing valid is available.
// Ports:
//   CLK, RSTn                      clock, async active-low reset
//   stall                          freeze outputs and PC advance
//   redirect, redirect_pc          branch/jump redirect (beats stall)
//   imem_req/addr/gnt/rvalid/rdata instruction memory handshake
//   inst, PCplus4, inst_valid      to IF/ID
//   PC                             next fetch PC
//   fetch_cnt                      valid-instruction count (IF_PERF_EN only)
// Build option: define IF_PERF_EN to add the fetch_cnt counter port.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] PCplus4,
  output logic            inst_valid,
  output logic [XLEN-1:0] PC
`ifdef IF_PERF_EN
  ,
  output logic [XLEN-1:0] fetch_cnt
`endif
);

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_kill;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_pcp4;
  logic            r_valid;

  state_t          w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_kill_nxt;
  logic            w_req_pc_ld;
  logic            w_new_vld;
  logic [XLEN-1:0] w_new_inst;
  logic [XLEN-1:0] w_new_pc;
  logic            w_out_en;
  logic            w_skid_load;
  logic            w_skid_drain;
  logic            w_skid_flush;
  logic            w_skid_valid;
  logic [XLEN-1:0] w_skid_inst;
  logic [XLEN-1:0] w_skid_pc;

  if_skid_buf u_skid (
    .clk     (CLK),
    .rst_n   (RSTn),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_flush (w_skid_flush),
    .i_inst  (imem_rdata),
    .i_pc    (r_req_pc),
    .o_valid (w_skid_valid),
    .o_inst  (w_skid_inst),
    .o_pc    (w_skid_pc)
  );

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state, PC, kill and output-register data selection.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_kill_nxt   = r_kill;
    w_req_pc_ld  = 1'b0;
    w_new_vld    = 1'b0;
    w_new_inst   = NOP_INST;
    w_new_pc     = r_req_pc;
    w_skid_load  = 1'b0;
    w_skid_drain = 1'b0;
    w_skid_flush = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_REQ;
      ST_REQ: begin
        // The request is masked while stalled, so a grant only counts then.
        if (imem_gnt && !stall) begin
          w_state_nxt = ST_WAIT;
          w_req_pc_ld = 1'b1;
          w_pc_nxt    = r_pc + PC_STEP;
          if (redirect) w_kill_nxt = 1'b1;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt = ST_REQ;
          w_kill_nxt  = 1'b0;
          if (!r_kill && !redirect) begin
            if (!stall) begin
              w_new_vld  = 1'b1;
              w_new_inst = imem_rdata;
            end else begin
              w_skid_load = 1'b1;
              w_state_nxt = ST_HOLD;
            end
          end
        end else if (redirect) begin
          w_kill_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          w_skid_flush = 1'b1;
          w_state_nxt  = ST_REQ;
        end else if (!stall && w_skid_valid) begin
          w_skid_drain = 1'b1;
          w_new_vld    = 1'b1;
          w_new_inst   = w_skid_inst;
          w_new_pc     = w_skid_pc;
          w_state_nxt  = ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (redirect) w_pc_nxt = align_pc(redirect_pc);
  end

  // A redirect always forces a bubble, even while stalled.
  assign w_out_en = redirect || !stall;

  // PC, request bookkeeping and IF/ID output register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_kill   <= 1'b0;
      r_inst   <= NOP_INST;
      r_pcp4   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_kill <= w_kill_nxt;
      if (w_req_pc_ld) r_req_pc <= r_pc;
      if (w_out_en) begin
        r_valid <= w_new_vld;
        r_inst  <= w_new_inst;
        if (w_new_vld) r_pcp4 <= w_new_pc + PC_STEP;
      end
    end
  end

`ifdef IF_PERF_EN
  logic [XLEN-1:0] r_fetch_cnt;

  // Counts output-register loads that carry a real instruction.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                      r_fetch_cnt <= '0;
    else if (w_out_en && w_new_vld) r_fetch_cnt <= r_fetch_cnt + 32'd1;
  end

  assign fetch_cnt = r_fetch_cnt;
`endif

  assign imem_req   = (r_state == ST_REQ) && !stall;
  assign imem_addr  = r_pc;
  assign PC         = r_pc;
  assign inst       = r_inst;
  assign PCplus4    = r_pcp4;
  assign inst_valid = r_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a transaction-level fetch model plus a
// simple one-outstanding memory; directed scenarios then random traffic.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, inst, pcplus4, pc;
`ifdef IF_PERF_EN
  logic [31:0] fetch_cnt;
`endif

  if_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .CLK         (clk),
    .RSTn        (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .PCplus4     (pcplus4),
    .inst_valid  (inst_valid),
    .PC          (pc)
`ifdef IF_PERF_EN
    ,
    .fetch_cnt   (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Model: PC, optional in-flight fetch, optional parked instruction.
  bit          m_first;
  bit          m_infl, m_kill, m_bv, m_valid;
  logic [31:0] m_pc, m_ipc, m_binst, m_bpc, m_inst, m_pcp4, m_cnt;
  bit          mem_pend;
  logic [31:0] last_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_first = 1'b1; m_infl = 1'b0; m_kill = 1'b0; m_bv = 1'b0; m_valid = 1'b0;
    m_pc = RST_PC; m_ipc = '0; m_binst = '0; m_bpc = '0;
    m_inst = '0; m_pcp4 = '0; m_cnt = '0;
  endtask

  // A fetch may be issued once out of reset with nothing in flight or parked.
  function automatic bit model_req(input bit st);
    return !m_first && !m_infl && !m_bv && !st;
  endfunction

  task automatic model_edge(input bit st, input bit rd, input logic [31:0] rpc,
                            input bit gnt, input bit rv, input logic [31:0] data);
    bit acc, got, dv;
    logic [31:0] dinst, dpc;
    acc = model_req(st) && gnt;
    got = m_infl && rv;
    dv = 1'b0; dinst = '0; dpc = '0;
    if (m_bv) begin
      if (rd) m_bv = 1'b0;
      else if (!st) begin dv = 1'b1; dinst = m_binst; dpc = m_bpc; m_bv = 1'b0; end
    end
    if (got && !m_kill && !rd) begin
      if (!st) begin dv = 1'b1; dinst = data; dpc = m_ipc; end
      else begin m_bv = 1'b1; m_binst = data; m_bpc = m_ipc; end
    end
    if (rd || !st) begin
      m_valid = dv;
      m_inst  = dv ? dinst : 32'h0;
      if (dv) m_pcp4 = dpc + 32'd4;
    end
    if (dv) m_cnt = m_cnt + 32'd1;
    if (acc) begin m_infl = 1'b1; m_ipc = m_pc; m_kill = rd; end
    else if (got) begin m_infl = 1'b0; m_kill = 1'b0; end
    else if (m_infl && rd) m_kill = 1'b1;
    if (rd) m_pc = {rpc[31:2], 2'b00};
    else if (acc) m_pc = m_pc + 32'd4;
    m_first = 1'b0;
  endtask

  // One clock cycle; called at posedge+1. rvm: 0 none, 1 respond if pending, 2 force rvalid.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit g, input int rvm);
    bit rv;
    stall = st; redirect = rd; redirect_pc = rpc;
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    #1;
    chk("imem_req", {31'b0, imem_req}, {31'b0, model_req(st)});
    chk("imem_addr", imem_addr, m_pc);
    imem_gnt = g & imem_req;
    rv = (rvm == 1 && mem_pend) || rvm == 2;
    imem_rvalid = rv;
    imem_rdata = $urandom;
    last_rdata = imem_rdata;
    if (rv) mem_pend = 1'b0;
    if (imem_gnt) mem_pend = 1'b1;
    model_edge(st, rd, rpc, imem_gnt, rv, imem_rdata);
    @(posedge clk); #1;
    chk("inst", inst, m_inst);
    chk("PCplus4", pcplus4, m_pcp4);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
    chk("PC", pc, m_pc);
`ifdef IF_PERF_EN
    chk("fetch_cnt", fetch_cnt, m_cnt);
`endif
  endtask

  // Asynchronous reset pulse starting at posedge+1; ends at posedge+1 released.
  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    #1;
    chk("rst PC", pc, 32'h0000_0100);
    chk("rst imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst imem_addr", imem_addr, 32'h0000_0100);
    chk("rst inst", inst, 32'h0);
    chk("rst PCplus4", pcplus4, 32'h0);
    chk("rst inst_valid", {31'b0, inst_valid}, 32'h0);
`ifdef IF_PERF_EN
    chk("rst fetch_cnt", fetch_cnt, 32'h0);
`endif
    model_reset();
    mem_pend = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    model_reset(); mem_pend = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Basic streaming from 0x100.
    step(0, 0, 0, 1, 1);
    chk("first req", {31'b0, imem_req}, 32'h1);
    chk("first addr", imem_addr, 32'h0000_0100);
    step(0, 0, 0, 1, 1);
    chk("pc after gnt", pc, 32'h0000_0104);
    step(0, 0, 0, 1, 1);
    chk("v1 valid", {31'b0, inst_valid}, 32'h1);
    chk("v1 pcp4", pcplus4, 32'h0000_0104);
    chk("v1 inst", inst, last_rdata);
    step(0, 0, 0, 1, 1);
    chk("bubble", {31'b0, inst_valid}, 32'h0);
    step(0, 0, 0, 1, 1);
    chk("v2 pcp4", pcplus4, 32'h0000_0108);
    step(0, 0, 0, 1, 1);
    // Stall while data for 0x108 returns.
    step(1, 0, 0, 1, 1);
    chk("stall valid", {31'b0, inst_valid}, 32'h0);
    chk("stall pcp4", pcplus4, 32'h0000_0108);
    step(1, 0, 0, 1, 1);
    chk("hold no req", {31'b0, imem_req}, 32'h0);
    step(0, 0, 0, 1, 1);
    chk("drain valid", {31'b0, inst_valid}, 32'h1);
    chk("drain pcp4", pcplus4, 32'h0000_010C);
    chk("post drain req", {31'b0, imem_req}, 32'h1);
    chk("post drain addr", imem_addr, 32'h0000_010C);
    // Redirect while waiting.
    step(0, 0, 0, 1, 0);
    step(0, 1, 32'h0000_0400, 1, 0);
    chk("redir pc", pc, 32'h0000_0400);
    step(0, 0, 0, 1, 1);
    chk("killed data", {31'b0, inst_valid}, 32'h0);
    chk("redir addr", imem_addr, 32'h0000_0400);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    chk("redir pcp4", pcplus4, 32'h0000_0404);
    // Redirect with grant, then with rvalid.
    step(0, 1, 32'h0000_0800, 1, 0);
    chk("gnt redir pc", pc, 32'h0000_0800);
    step(0, 0, 0, 1, 1);
    chk("gnt kill", {31'b0, inst_valid}, 32'h0);
    chk("gnt redir addr", imem_addr, 32'h0000_0800);
    step(0, 0, 0, 1, 0);
    step(0, 1, 32'h0000_0900, 1, 1);
    chk("rv kill", {31'b0, inst_valid}, 32'h0);
    chk("rv redir pc", pc, 32'h0000_0900);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    chk("rv redir pcp4", pcplus4, 32'h0000_0904);
    // Wrap around the top of the address space.
    step(0, 1, 32'hFFFF_FFFF, 0, 0);
    chk("aligned pc", pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 0);
    chk("wrap pc", pc, 32'h0000_0000);
    step(0, 0, 0, 1, 1);
    chk("wrap pcp4", pcplus4, 32'h0000_0000);
    chk("wrap valid", {31'b0, inst_valid}, 32'h1);
    chk("wrap addr", imem_addr, 32'h0000_0000);
    // Reset in the middle of a fetch, then a stray response.
    step(0, 0, 0, 1, 0);
    do_reset();
    step(0, 0, 0, 0, 2);
    chk("stray ignored", {31'b0, inst_valid}, 32'h0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      else step(($urandom % 4) == 0, ($urandom % 10) == 0, $urandom,
                ($urandom % 3) != 0,
                (($urandom % 25) == 0) ? 2 : ((($urandom % 3) != 0) ? 1 : 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
